// File: rtl/axi_regfile_responder.sv
// axi_regfile_responder: single-outstanding AXI4 slave backed by a 64-bit register file.
// Optional AXI_REGFILE_WRAP_EN adds WRAP burst support; without it WRAP bursts are errored.
package ariane_axi;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;
    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        b_t   b;
        logic r_valid;
        r_t   r;
    } resp_t;
endpackage

module axi_regfile_responder #(
    parameter int unsigned NumWords   = 16,
    parameter logic [63:0] BaseAddr   = 64'h0,
    parameter int unsigned AxiIdWidth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  ariane_axi::req_t   axi_req_i,
    output ariane_axi::resp_t  axi_resp_o
);
    localparam int unsigned IW = $clog2(NumWords);
    localparam logic [1:0] INCR = 2'd1, WRAP = 2'd2, OKAY = 2'd0, SLVERR = 2'd2;
    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t r_state, w_next;
    logic r_last_wr;
    logic [AxiIdWidth-1:0] r_id;
    logic [63:0] r_addr;
    logic [7:0] r_len, r_cnt;
    logic [1:0] r_burst;
    logic r_bad, r_err;
    logic [63:0] r_mem [NumWords];
    logic [63:0] w_off, w_next_addr;
    logic [IW-1:0] w_idx;
    logic w_grant_aw, w_grant_ar, w_wrap_ok, w_ax_bad, w_in_range, w_beat_ok, w_final;
    logic w_wr_hs, w_rd_hs;
    ariane_axi::ax_t w_ax;

    // Round robin on contention: grant the channel opposite to the last one served
    assign w_grant_aw = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !r_last_wr);
    assign w_grant_ar = axi_req_i.ar_valid && !w_grant_aw;
    assign w_ax       = w_grant_aw ? axi_req_i.aw : axi_req_i.ar;
`ifdef AXI_REGFILE_WRAP_EN
    logic [63:0] w_mask;
    assign w_mask      = {53'd0, r_len, 3'b111};
    assign w_wrap_ok   = (w_ax.len inside {8'd1, 8'd3, 8'd7, 8'd15}) && w_ax.addr[2:0] == 3'd0;
    assign w_next_addr = r_burst == INCR ? r_addr + 64'd8 :
                         r_burst == WRAP ? (r_addr & ~w_mask) | ((r_addr + 64'd8) & w_mask) : r_addr;
`else
    assign w_wrap_ok   = 1'b0;
    assign w_next_addr = r_burst == INCR ? r_addr + 64'd8 : r_addr;
`endif
    assign w_ax_bad   = w_ax.size != 3'd3 || w_ax.burst == 2'b11 || (w_ax.burst == WRAP && !w_wrap_ok);
    assign w_off      = r_addr - BaseAddr;
    assign w_idx      = w_off[IW+2:3];
    assign w_in_range = w_off < 64'(NumWords) * 64'd8;
    assign w_beat_ok  = !r_bad && w_in_range;
    assign w_final    = r_cnt == r_len;
    assign w_wr_hs    = r_state == WDATA && axi_req_i.w_valid;
    assign w_rd_hs    = r_state == RDATA && axi_req_i.r_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        axi_resp_o = '0;
        case (r_state)
            IDLE: begin
                axi_resp_o.aw_ready = w_grant_aw;
                axi_resp_o.ar_ready = w_grant_ar;
                w_next = w_grant_aw ? WDATA : w_grant_ar ? RDATA : IDLE;
            end
            WDATA: begin
                axi_resp_o.w_ready = 1'b1;
                w_next = axi_req_i.w_valid && w_final ? WRESP : WDATA;
            end
            WRESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = r_id;
                axi_resp_o.b.resp  = r_err ? SLVERR : OKAY;
                w_next = axi_req_i.b_ready ? IDLE : WRESP;
            end
            RDATA: begin
                axi_resp_o.r_valid = 1'b1;
                axi_resp_o.r.id    = r_id;
                axi_resp_o.r.data  = w_beat_ok ? r_mem[w_idx] : 64'd0;
                axi_resp_o.r.resp  = w_beat_ok ? OKAY : SLVERR;
                axi_resp_o.r.last  = w_final;
                w_next = axi_req_i.r_ready && w_final ? IDLE : RDATA;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_wr <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_bad     <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < NumWords; i++) r_mem[i] <= '0;
        end else begin
            if (r_state == IDLE && (w_grant_aw || w_grant_ar)) begin
                r_last_wr <= w_grant_aw;
                r_id      <= w_ax.id;
                r_addr    <= w_ax.addr;
                r_len     <= w_ax.len;
                r_burst   <= w_ax.burst;
                r_bad     <= w_ax_bad;
                r_err     <= w_ax_bad;
                r_cnt     <= '0;
            end
            if (w_wr_hs || w_rd_hs) begin
                r_addr <= w_next_addr;
                r_cnt  <= r_cnt + 8'd1;
            end
            // A misplaced or missing w.last poisons the response but never shortens the burst
            if (w_wr_hs) begin
                r_err <= r_err | !w_beat_ok | (axi_req_i.w.last != w_final);
                if (w_beat_ok)
                    for (int i = 0; i < 8; i++)
                        if (axi_req_i.w.strb[i]) r_mem[w_idx][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
            end
        end
    end
endmodule
